// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller.
package lsu_pkg;

  // Memory operation encodings as presented by the execute stage.
  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  // Transaction engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return !is_store(op);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory bus of the load/store controller.
// The master modport is the controller's view; slave is the environment's.
interface lsu_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data replication, load extraction
// with sign/zero extension, and the natural-alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to lane 0.
  assign shifted = rdata >> {a, 3'b000};

  // Per-operation lane decode; loads always read the full word.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = shifted;
    misalign  = 1'b0;
    case (op)
      OP_LB:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH: begin
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        misalign  = a[0];
      end
      OP_LW:  misalign = (a != 2'b00);
      OP_LBU: rdata_ext = {24'h000000, shifted[7:0]};
      OP_LHU: begin
        rdata_ext = {16'h0000, shifted[15:0]};
        misalign  = a[0];
      end
      OP_SB: begin
        be        = 4'b0001 << a;
        wdata_rep = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be        = 4'b0011 << a;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = a[0];
      end
      OP_SW:  misalign = (a != 2'b00);
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequenced load/store engine: accepts one request, checks it, runs a
// req/gnt/rvalid exchange with data memory under a watchdog, and returns
// a one-cycle response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input logic    clk,
  input logic    rst_n,
  lsu_if.master  bus
);

  // A zero TIMEOUT disables the watchdog but still needs a legal counter width.
  localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  lsu_state_e        state;
  lsu_state_e        state_nxt;
  mem_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  mem_op_e     align_op;
  logic [1:0]  align_a;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        out_of_range;
  logic        accept;
  logic        accept_err;
  logic        timeout_hit;
  logic        timeout_exit;
  logic        in_req;
  logic        in_done;

  // The aligner checks the incoming request in IDLE and serves the held
  // request afterwards.
  assign align_op = (state == ST_IDLE) ? mem_op_e'(bus.req_op) : op_q;
  assign align_a  = (state == ST_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .op        (align_op),
    .a         (align_a),
    .wdata     (wdata_q),
    .rdata     (bus.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign out_of_range = ((bus.req_addr >> ADDR_W) != 32'd0);
  assign accept       = (state == ST_IDLE) && bus.req_valid;
  assign accept_err   = misalign || out_of_range;
  assign timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Next-state decode; a grant or rvalid in the last watchdog cycle still wins.
  always_comb begin
    state_nxt    = state;
    timeout_exit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = accept_err ? ST_DONE : ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          state_nxt = is_store(op_q) ? ST_DONE : ST_WAIT;
        end else if (timeout_hit) begin
          state_nxt    = ST_DONE;
          timeout_exit = 1'b1;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          state_nxt    = ST_DONE;
          timeout_exit = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Watchdog: restart on entry to REQ, count every REQ/WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (accept && !accept_err) begin
      cnt <= {CNT_W{1'b0}};
    end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Capture the request at accept; it drives the memory bus until done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_LB;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 32'h0000_0000;
    end else if (accept) begin
      op_q    <= mem_op_e'(bus.req_op);
      addr_q  <= bus.req_addr[ADDR_W-1:0];
      wdata_q <= bus.req_wdata;
    end else begin
      op_q    <= op_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
    end
  end

  // Response payload: error at accept, load data on rvalid, error on timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= accept_err;
    end else if ((state == ST_WAIT) && bus.mem_rvalid) begin
      rdata_q <= rdata_ext;
      err_q   <= 1'b0;
    end else if (timeout_exit) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b1;
    end else begin
      rdata_q <= rdata_q;
      err_q   <= err_q;
    end
  end

  // Outputs decode from registered state and are forced low while in reset.
  assign in_req  = rst_n && (state == ST_REQ);
  assign in_done = rst_n && (state == ST_DONE);

  assign bus.req_ready = rst_n && (state == ST_IDLE);
  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req && is_store(op_q);
  assign bus.mem_be    = in_req ? be : 4'b0000;
  assign bus.mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
  assign bus.mem_wdata = (in_req && is_store(op_q)) ? wdata_rep : 32'h0000_0000;
  assign bus.rsp_valid = in_done;
  assign bus.rsp_rdata = in_done ? rdata_q : 32'h0000_0000;
  assign bus.rsp_err   = in_done && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (ADDR_W=12, TIMEOUT=8) with a cycle-driven
// memory responder and hand-computed expectations.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(12)) bus ();

  lsu_ctrl #(.ADDR_W(12), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Results of the last transaction
  int          r_lat;
  int          r_reqc;
  logic [31:0] r_rd;
  logic        r_err;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic [11:0] r_ma;
  logic        r_we;
  logic        r_stable;
  logic        r_post_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    return {23'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_req, bus.mem_we,
            |bus.mem_be, |bus.rsp_rdata, |bus.mem_addr, |bus.mem_wdata};
  endfunction

  // Issue one request and play memory: grant after gnt_wait REQ cycles, rvalid
  // rv_wait cycles after the grant (-1 = never). early_rv also pulses rvalid
  // with wrong data in the grant cycle.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input bit early_rv);
    int g;
    g = -1;
    r_lat = -1; r_reqc = 0; r_rd = 32'd0; r_err = 1'b0; r_be = 4'd0;
    r_wd = 32'd0; r_ma = 12'd0; r_we = 1'b0; r_stable = 1'b1; r_post_ok = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = rdata;
      if (bus.rsp_valid) begin
        r_lat = c; r_rd = bus.rsp_rdata; r_err = bus.rsp_err;
        break;
      end
      if (bus.mem_req) begin
        r_reqc++;
        if (r_reqc == 1) begin
          r_be = bus.mem_be; r_wd = bus.mem_wdata; r_ma = bus.mem_addr; r_we = bus.mem_we;
        end else if (r_be != bus.mem_be || r_wd != bus.mem_wdata ||
                     r_ma != bus.mem_addr || r_we != bus.mem_we) begin
          r_stable = 1'b0;
        end
        if (r_reqc > gnt_wait) begin
          bus.mem_gnt = 1'b1;
          g = c;
          if (early_rv) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = ~rdata;
          end
        end
      end
      if (g >= 0 && rv_wait > 0 && c == g + rv_wait) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
      end
      tick();
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    if (r_lat >= 0) begin
      tick();
      r_post_ok = bus.req_ready && !bus.rsp_valid && !bus.rsp_err &&
                  (bus.rsp_rdata == 32'd0) && !bus.mem_req;
    end
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int nrsp;
    bus.req_valid = 1'b1; bus.req_op = 3'b010; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    rst_n = 1'b0;
    tick(); tick();
    check_eq("reset_outs_zero", outs_vec(), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("idle_ready", {31'd0, bus.req_ready}, 32'd1);

    // SB at 0x003
    do_txn(3'b101, 32'h0000_0003, 32'h0000_00A5, 0, -1, 32'd0, 1'b0);
    check_eq("sb_lat", r_lat, 32'd2);
    check_eq("sb_be", {28'd0, r_be}, 32'h8);
    check_eq("sb_wdata", r_wd, 32'hA5A5_A5A5);
    check_eq("sb_addr", {20'd0, r_ma}, 32'h000);
    check_eq("sb_we_err", {30'd0, r_we, r_err}, 32'b10);
    check_eq("sb_post", {31'd0, r_post_ok}, 32'd1);

    // LH / LHU at 0x006
    do_txn(3'b001, 32'h0000_0006, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
    check_eq("lh_lat", r_lat, 32'd3);
    check_eq("lh_data", r_rd, 32'hFFFF_8001);
    check_eq("lh_be_we", {27'd0, r_be, r_we}, {27'd0, 4'hF, 1'b0});
    check_eq("lh_addr", {20'd0, r_ma}, 32'h004);
    do_txn(3'b100, 32'h0000_0006, 32'd0, 0, 1, 32'h8001_1234, 1'b0);
    check_eq("lhu_data", r_rd, 32'h0000_8001);
    check_eq("lhu_err", {31'd0, r_err}, 32'd0);

    // Misaligned LW and out-of-range LB
    do_txn(3'b010, 32'h0000_0002, 32'd0, 0, 1, 32'd0, 1'b0);
    check_eq("lw_mis_lat", r_lat, 32'd1);
    check_eq("lw_mis_err", {31'd0, r_err}, 32'd1);
    check_eq("lw_mis_noreq", r_reqc, 32'd0);
    check_eq("lw_mis_post", {31'd0, r_post_ok}, 32'd1);
    do_txn(3'b000, 32'h0000_1000, 32'd0, 0, 1, 32'd0, 1'b0);
    check_eq("lb_oor_lat", r_lat, 32'd1);
    check_eq("lb_oor_err", {31'd0, r_err}, 32'd1);
    check_eq("lb_oor_noreq", r_reqc, 32'd0);

    // LW, gnt withheld 3 cycles, rvalid 2 later; stray rvalid in grant cycle
    do_txn(3'b010, 32'h0000_0010, 32'd0, 3, 2, 32'hDEAD_BEEF, 1'b1);
    check_eq("lw_wait_reqc", r_reqc, 32'd4);
    check_eq("lw_wait_stable", {31'd0, r_stable}, 32'd1);
    check_eq("lw_wait_lat", r_lat, 32'd7);
    check_eq("lw_wait_data", r_rd, 32'hDEAD_BEEF);
    check_eq("lw_wait_addr", {20'd0, r_ma}, 32'h010);

    // SH at 0x002, SW at 0x00C, LB at 0x005
    do_txn(3'b110, 32'h0000_0002, 32'h1234_ABCD, 0, -1, 32'd0, 1'b0);
    check_eq("sh_be", {28'd0, r_be}, 32'hC);
    check_eq("sh_wdata", r_wd, 32'hABCD_ABCD);
    check_eq("sh_lat", r_lat, 32'd2);
    do_txn(3'b111, 32'h0000_000C, 32'h0123_4567, 1, -1, 32'd0, 1'b0);
    check_eq("sw_be_we", {27'd0, r_be, r_we}, {27'd0, 4'hF, 1'b1});
    check_eq("sw_wdata", r_wd, 32'h0123_4567);
    check_eq("sw_lat", r_lat, 32'd3);
    do_txn(3'b000, 32'h0000_0005, 32'd0, 0, 1, 32'h0000_8000, 1'b0);
    check_eq("lb_sext", r_rd, 32'hFFFF_FF80);

    // Watchdog: granted load with no rvalid, then no grant at all
    do_txn(3'b010, 32'h0000_0020, 32'd0, 0, -1, 32'd0, 1'b0);
    check_eq("to_wait_lat", r_lat, 32'd9);
    check_eq("to_wait_err_rd", {r_rd[30:0], r_err}, 32'd1);
    check_eq("to_wait_post", {31'd0, r_post_ok}, 32'd1);
    do_txn(3'b010, 32'h0000_0020, 32'd0, 100, -1, 32'd0, 1'b0);
    check_eq("to_req_reqc", r_reqc, 32'd8);
    check_eq("to_req_lat", r_lat, 32'd9);
    check_eq("to_req_err", {31'd0, r_err}, 32'd1);

    // Reset during WAIT
    bus.req_valid = 1'b1; bus.req_op = 3'b010; bus.req_addr = 32'd0;
    tick();
    bus.req_valid = 1'b0;
    check_eq("rst_txn_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs_zero", outs_vec(), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    nrsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) nrsp++;
      tick();
    end
    bus.mem_rvalid = 1'b0;
    check_eq("rst_no_rsp", nrsp, 32'd0);
    check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    do_txn(3'b011, 32'h0000_0001, 32'd0, 0, 1, 32'h0000_FF00, 1'b0);
    check_eq("lbu_after_rst", r_rd, 32'h0000_00FF);
    check_eq("lbu_after_rst_lat", r_lat, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Parametrised load/store controller between the execute stage and the data memory. It replaces the purely combinational size/extend path with a sequenced transaction engine. It accepts one load or store per handshake and checks alignment and address range. It generates byte enables and lane-replicated write data, runs a request/grant/rvalid protocol toward memory with a watchdog timeout, and returns a byte-lane-extracted, sign/zero-extended load result or an error flag.

## Interface
Parameters:
- ADDR_W, 12, byte-address width of data memory; upper request bits must be zero.
- TIMEOUT, 64, max cycles in REQ+WAIT before error; 0 disables watchdog.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  controller accepts request (high only in IDLE)
- req_op  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half/word used)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or timeout; valid with rsp_valid
- mem_req  out  1  memory request, held until mem_gnt
- mem_gnt  in  1  memory accepts request this cycle
- mem_we  out  1  1 = store
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned byte address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  raw memory word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. On req_valid, register op, addr and wdata.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) or out-of-range (addr[31:ADDR_W]≠0): go to DONE with err=1. No memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1 and mem_we/be/addr/wdata stable from the registered request.
  - On mem_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on mem_rvalid, capture the extracted result and go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- Watchdog: counter cleared on entry to REQ and incremented each cycle in REQ/WAIT. When it reaches TIMEOUT, go to DONE with err=1 and drop mem_req.
- Byte enables, with a = addr[1:0]:
  - SB: 4'b0001<<a
  - SH: 4'b0011<<a
  - SW: 4'b1111
  - loads: 4'b1111
- Write data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extract: rdata>>(8*a), then LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW pass-through.
- mem_rvalid outside WAIT (including the grant cycle) is ignored. Memory must not respond after a timeout; a late response is not attributed.

## Timing
- Reset (rst_n low at clk edge): state IDLE, counter 0. All outputs 0, including req_ready, while rst_n is low. Reset mid-transaction aborts it with no rsp_valid.
- Store, gnt on first REQ cycle: accept c0, REQ c1, rsp_valid c2 (latency 2).
- Load, gnt c1, rvalid c2: rsp_valid c3 (latency 3).
- Error at accept: rsp_valid c1.
- No response backpressure; the next request can be accepted the cycle after DONE.
- rsp_rdata and rsp_err hold their value only during rsp_valid and are 0 otherwise.

## Structure
- Shared package lsu_pkg: mem_op_e enum (8 encodings above), lsu_state_e, and is_store/is_load helper functions.
- Sub-module lsu_align (combinational): op + addr[1:0] + wdata/rdata in, be, replicated wdata, extracted rdata and misalign flag out. lsu_ctrl holds the FSM, request registers and watchdog.
- Counter width $clog2(TIMEOUT+1).

## Test plan
- SB, addr 0x003, wdata 0x000000A5, gnt immediate → mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_addr 0x000, rsp_valid 2 cycles after accept, err 0.
- LH, addr 0x006, mem_rdata 0x8001_1234 → rsp_rdata 0xFFFF8001. LHU at the same address → 0x00008001.
- LW, addr 0x002 → rsp_err=1 one cycle after accept, mem_req never asserted. LB, addr 0x0000_1000 (ADDR_W=12) → out-of-range err.
- LW, mem_gnt withheld 3 cycles, then rvalid 2 cycles later with 0xDEADBEEF → mem_req held 4 cycles, rsp_rdata 0xDEADBEEF.
- TIMEOUT=8, load granted, rvalid never → rsp_err=1 after 8 cycles in REQ+WAIT, back to IDLE.
- rst_n low during WAIT → no rsp_valid, all outputs 0. The next LBU at 0x001 with rdata 0x0000FF00 → 0x000000FF.
